pc_redirect_ctrl: RTL and testbench
===================================

Name: pc_redirect_ctrl

Overview:
- Next-PC sequencer for the 5-stage MIPS pipeline. Owns the architectural PC register and arbitrates between sequential fetch, ID-stage jump redirects and EX-stage taken-branch redirects.
- Generates IF/ID and ID/EX flush strobes for each redirect.
- Honours the hazard-unit stall by holding the PC and buffering any redirect raised during the stall.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of saturating redirect performance counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- stall  input  1  hazard-unit freeze of PC and IF/ID
- jmp_req  input  1  ID stage holds a J-type instruction
- jmp_addr  input  32  jump target from ID decode
- br_taken  input  1  EX stage resolved a taken branch
- br_target  input  32  branch target from EX
- pc  output  32  current fetch address, registered
- pc_plus4  output  32  pc + 4, combinational
- if_id_flush  output  1  kill the instruction entering IF/ID
- id_ex_flush  output  1  kill the instruction entering ID/EX
- redirect_pending  output  1  a redirect is buffered behind a stall
- jmp_cnt  output  CNT_W  jumps applied, saturating
- br_cnt  output  CNT_W  branches applied, saturating

Behaviour:
- Reset, checked at the clock edge and dominant over all other inputs: pc=RESET_VECTOR, state=RUN, pending buffer cleared, jmp_cnt=br_cnt=0. During reset the flushes read 0 and redirect_pending reads 0.
- Targets: bits [1:0] of jmp_addr and br_target are ignored and forced to 2'b00 before use. Address arithmetic is modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- Priority within a cycle: br_taken > jmp_req > sequential. A branch is older than a jump in ID, so it wins and the jump is discarded.
- States:
  - RUN: no redirect is buffered.
  - PEND: a stall is active and a redirect is buffered.
- RUN, stall=0:
  - br_taken: pc<=br_target; if_id_flush=id_ex_flush=1 in the same cycle; br_cnt++.
  - else jmp_req: pc<=jmp_addr; if_id_flush=1, id_ex_flush=0; jmp_cnt++.
  - else pc<=pc+4; no flush.
- RUN, stall=1:
  - pc holds.
  - br_taken or jmp_req: capture the winning target and source into the pending buffer; go to PEND; no flush this cycle.
- PEND, stall=1:
  - pc holds.
  - A new br_taken overwrites a buffered jump.
  - A new br_taken also overwrites a buffered branch; the newest target is kept.
  - jmp_req never overwrites a buffered branch.
  - jmp_req overwrites a buffered jump.
- PEND, stall=0:
  - Live br_taken in this cycle beats the buffered entry.
  - Otherwise apply the buffered redirect: pc<=target, with flushes and counter per source exactly as in RUN.
  - Clear the buffer and go to RUN.
- redirect_pending=1 iff state==PEND.
- Flush outputs are combinational from the current state and inputs. They are asserted only in the cycle the PC is actually redirected.
- Counters saturate at all-ones and never wrap.
- Reset mid-PEND discards the buffered redirect; no flush is emitted.

Decomposition:
- Shared package pc_ctrl_pkg:
  - RESET_VECTOR default.
  - Redirect source enum SRC_NONE/SRC_JMP/SRC_BR.
  - State enum RUN/PEND.
  - Constant PC_INC=32'd4.
- Sub-module pc_redirect_buf: the pending buffer holding valid, source and target. It takes load/clear inputs and applies the overwrite priority rules. The top level keeps the FSM, PC register, flush logic and counters.

Test Plan:
- Reset then 3 idle cycles -> pc sequence 0x0, 0x4, 0x8, 0xC; all flushes 0; counters 0.
- At pc=0x10, jmp_req with jmp_addr=0x0000_0043 -> next pc=0x40; if_id_flush=1 for exactly 1 cycle; id_ex_flush=0; jmp_cnt=1.
- Same cycle jmp_req (jmp_addr 0x100) and br_taken (br_target 0x200) -> pc=0x200; both flushes 1; br_cnt=1; jmp_cnt unchanged.
- stall=1 for 3 cycles, jmp_req=0x80 in cycle 1, br_taken=0x300 in cycle 2 -> pc held; redirect_pending=1 from cycle 2. First unstalled cycle: pc<=0x300, both flushes 1, br_cnt++, jmp_cnt unchanged.
- PEND holding jump 0x80, then reset asserted -> pc=RESET_VECTOR, redirect_pending=0, no flush; the following cycle pc=0x4.
- Force jmp_cnt to all-ones via 2^CNT_W jumps (CNT_W=4 build: 16 jumps, then one more) -> jmp_cnt stays 4'hF.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the next-PC sequencer.
// Contents:
//   RESET_VECTOR_DEFAULT : default PC after reset
//   PC_INC               : sequential fetch increment
//   src_e                : redirect source (none / jump / branch)
//   state_e              : sequencer state (RUN / PEND)
//   word_align()         : clears bits [1:0] of a redirect target
package pc_ctrl_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC               = 32'd4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2
  } src_e;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  // Instruction fetch is word aligned; low target bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer: holds one redirect raised while the PC is stalled.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   load, load_src,
//   load_target           : offer a new redirect (source + aligned target)
//   clear                 : drop the buffered entry (dominates load)
//   valid, src, target    : current buffered entry
// Overwrite rule: a new entry replaces the stored one unless the stored
// entry is a branch and the new one is a jump (the branch is older).
import pc_ctrl_pkg::*;

module pc_redirect_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  src_e        load_src,
  input  logic [31:0] load_target,
  input  logic        clear,
  output logic        valid,
  output src_e        src,
  output logic [31:0] target
);

  logic        valid_reg, valid_next;
  src_e        src_reg, src_next;
  logic [31:0] target_reg, target_next;
  logic        take_new;

  assign take_new = load && !(valid_reg && (src_reg == SRC_BR) && (load_src == SRC_JMP));

  always_comb begin
    valid_next  = valid_reg;
    src_next    = src_reg;
    target_next = target_reg;
    if (clear) begin
      valid_next  = 1'b0;
      src_next    = SRC_NONE;
      target_next = '0;
    end else if (take_new) begin
      valid_next  = 1'b1;
      src_next    = load_src;
      target_next = load_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      src_reg    <= SRC_NONE;
      target_reg <= '0;
    end else begin
      valid_reg  <= valid_next;
      src_reg    <= src_next;
      target_reg <= target_next;
    end
  end

  assign valid  = valid_reg;
  assign src    = src_reg;
  assign target = target_reg;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer for the 5-stage pipeline.
// Owns the PC register and arbitrates sequential fetch, ID jumps and EX
// branches (branch > jump > sequential). Redirects raised under stall are
// buffered and applied on the first unstalled cycle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hazard-unit freeze of PC and IF/ID
//   jmp_req, jmp_addr   : ID-stage jump and target
//   br_taken, br_target : EX-stage taken branch and target
//   pc, pc_plus4        : registered fetch address and pc+4
//   if_id_flush,
//   id_ex_flush         : pipeline kill strobes, only in redirect cycle
//   redirect_pending    : a redirect is buffered behind a stall
//   jmp_cnt, br_cnt     : saturating counts of applied redirects
import pc_ctrl_pkg::*;

module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jmp_req,
  input  logic [31:0]      jmp_addr,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] jmp_cnt,
  output logic [CNT_W-1:0] br_cnt
);

  state_e      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;

  src_e        live_src;
  logic [31:0] live_target;
  src_e        apply_src;
  logic [31:0] apply_target;

  logic        buf_valid;
  src_e        buf_src;
  logic [31:0] buf_target;
  logic        buf_load;
  logic        buf_clear;

  // Winning redirect presented this cycle, before stall is considered.
  always_comb begin
    live_src    = SRC_NONE;
    live_target = '0;
    if (br_taken) begin
      live_src    = SRC_BR;
      live_target = word_align(br_target);
    end else if (jmp_req) begin
      live_src    = SRC_JMP;
      live_target = word_align(jmp_addr);
    end
  end

  // FSM next state and the redirect actually applied to the PC.
  // Only a live branch beats a buffered entry; a live jump in the release
  // cycle is younger than whatever was buffered and is dropped.
  always_comb begin
    state_next   = state_reg;
    apply_src    = SRC_NONE;
    apply_target = '0;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (stall) begin
            if (live_src != SRC_NONE) begin
              buf_load   = 1'b1;
              state_next = PEND;
            end
          end else begin
            apply_src    = live_src;
            apply_target = live_target;
          end
        end
        PEND: begin
          if (stall) begin
            buf_load = (live_src != SRC_NONE);
          end else begin
            buf_clear  = 1'b1;
            state_next = RUN;
            if (live_src == SRC_BR) begin
              apply_src    = SRC_BR;
              apply_target = live_target;
            end else begin
              apply_src    = buf_src;
              apply_target = buf_target;
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    pc_next = pc_reg;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else if (!stall) begin
      pc_next = (apply_src == SRC_NONE) ? pc_reg + PC_INC : apply_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      pc_reg    <= RESET_VECTOR;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  pc_redirect_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (buf_load),
    .load_src    (live_src),
    .load_target (live_target),
    .clear       (buf_clear),
    .valid       (buf_valid),
    .src         (buf_src),
    .target      (buf_target)
  );

  // Saturating counters: index 0 counts jumps, index 1 counts branches.
  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_all;

  assign cnt_inc[0] = (apply_src == SRC_JMP);
  assign cnt_inc[1] = (apply_src == SRC_BR);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign pc               = pc_reg;
  assign pc_plus4         = pc_reg + PC_INC;
  assign if_id_flush      = (apply_src != SRC_NONE);
  assign id_ex_flush      = (apply_src == SRC_BR);
  // buf_valid tracks PEND by construction; both are kept in step.
  assign redirect_pending = (state_reg == PEND) && buf_valid;
  assign jmp_cnt          = cnt_all[0];
  assign br_cnt           = cnt_all[1];

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_pc_redirect_ctrl;

  localparam int CNT_W = 4;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset, stall, jmp_req, br_taken;
  logic [31:0]      jmp_addr, br_target;
  logic [31:0]      pc, pc_plus4;
  logic             if_id_flush, id_ex_flush, redirect_pending;
  logic [CNT_W-1:0] jmp_cnt, br_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state: pending slot kind 0=none 1=jump 2=branch.
  bit          m_init = 0;
  logic [31:0] m_pc;
  int          m_pkind;
  logic [31:0] m_ptgt;
  int          m_jc, m_bc;

  pc_redirect_ctrl #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .jmp_req          (jmp_req),
    .jmp_addr         (jmp_addr),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .redirect_pending (redirect_pending),
    .jmp_cnt          (jmp_cnt),
    .br_cnt           (br_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance model.
  task automatic step(input bit r, input bit s, input bit j, input logic [31:0] ja,
                      input bit b, input logic [31:0] bt);
    int          app;
    logic [31:0] tgt;
    logic [31:0] aja, abt;
    reset = r; stall = s; jmp_req = j; jmp_addr = ja; br_taken = b; br_target = bt;
    aja = ja & 32'hFFFF_FFFC;
    abt = bt & 32'hFFFF_FFFC;
    @(negedge clk);
    app = 0; tgt = '0;
    if (!r && !s) begin
      if (b)                 begin app = 2; tgt = abt; end
      else if (m_pkind != 0) begin app = m_pkind; tgt = m_ptgt; end
      else if (j)            begin app = 1; tgt = aja; end
    end
    check("if_id_flush", 32'(if_id_flush), 32'(app != 0));
    check("id_ex_flush", 32'(id_ex_flush), 32'(app == 2));
    if (m_init) begin
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("pending", 32'(redirect_pending), 32'(m_pkind != 0));
      check("jmp_cnt", 32'(jmp_cnt), 32'(m_jc));
      check("br_cnt", 32'(br_cnt), 32'(m_bc));
    end
    $display("cyc t=%0t rst=%0b stall=%0b j=%0b ja=%h b=%0b bt=%h pc=%h flush=%0b%0b pend=%0b jc=%0d bc=%0d",
             $time, r, s, j, ja, b, bt, pc, if_id_flush, id_ex_flush, redirect_pending, jmp_cnt, br_cnt);
    @(posedge clk);
    #1;
    if (r) begin
      m_init = 1; m_pc = RV; m_pkind = 0; m_ptgt = '0; m_jc = 0; m_bc = 0;
    end else if (s) begin
      if (b) begin m_pkind = 2; m_ptgt = abt; end
      else if (j && m_pkind != 2) begin m_pkind = 1; m_ptgt = aja; end
    end else begin
      m_pc = (app == 0) ? m_pc + 32'd4 : tgt;
      if (app == 1 && m_jc < (1 << CNT_W) - 1) m_jc++;
      if (app == 2 && m_bc < (1 << CNT_W) - 1) m_bc++;
      m_pkind = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    reset = 1; stall = 0; jmp_req = 0; br_taken = 0; jmp_addr = '0; br_target = '0;
    step(1, 0, 0, '0, 0, '0);
    check("reset_pc", pc, RV);
    check("reset_cnt", 32'(jmp_cnt) + 32'(br_cnt), 32'd0);
    idle(4);
    check("seq_pc", pc, 32'h10);

    step(0, 0, 1, 32'h0000_0043, 0, '0);
    check("jmp_pc", pc, 32'h40);
    check("jmp_cnt1", 32'(jmp_cnt), 32'd1);
    idle(1);

    step(0, 0, 1, 32'h100, 1, 32'h200);
    check("br_over_jmp_pc", pc, 32'h200);
    check("br_cnt1", 32'(br_cnt), 32'd1);
    check("jmp_cnt_kept", 32'(jmp_cnt), 32'd1);

    step(0, 1, 1, 32'h80, 0, '0);
    step(0, 1, 0, '0, 1, 32'h300);
    step(0, 1, 1, 32'h500, 0, '0);
    check("pend_set", 32'(redirect_pending), 32'd1);
    check("pc_held", pc, 32'h200);
    step(0, 0, 0, '0, 0, '0);
    check("pend_apply_pc", pc, 32'h300);
    check("br_cnt2", 32'(br_cnt), 32'd2);

    step(0, 1, 1, 32'h80, 0, '0);
    check("pend_jmp", 32'(redirect_pending), 32'd1);
    step(1, 1, 0, '0, 0, '0);
    check("rst_pend_pc", pc, RV);
    check("rst_pend_clr", 32'(redirect_pending), 32'd0);
    idle(1);
    check("after_rst_pc", pc, 32'h4);

    step(0, 0, 1, 32'hFFFF_FFFF, 0, '0);
    check("wrap_tgt", pc, 32'hFFFF_FFFC);
    idle(1);
    check("wrap_pc", pc, 32'h0);

    for (int i = 0; i < 17; i++) step(0, 0, 1, 32'h40 + 32'(i * 4), 0, '0);
    check("jmp_sat", 32'(jmp_cnt), 32'hF);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 30, $urandom,
           $urandom_range(0, 99) < 20, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
